// File: rtl/dwt_feat_pkg.sv
// Shared constants and helpers for the DWT sub-band feature extractor.
package dwt_feat_pkg;

  localparam int COEFF_W = 32;
  localparam logic [COEFF_W-1:0] ABS_MAX = 32'h7FFF_FFFF;

  // Accumulator width: enough headroom for LENGTH full-scale coefficients.
  function automatic int f_aw(input int len);
    return COEFF_W + $clog2(len);
  endfunction

endpackage

// File: rtl/dwt_feat_abs.sv
// Combinational saturating absolute value of a signed coefficient.
module dwt_feat_abs
  import dwt_feat_pkg::*;
(
  input  logic signed [COEFF_W-1:0] x,
  output logic        [COEFF_W-1:0] y
);

  // The most negative value has no positive twin, so it clamps to the largest positive one.
  always_comb begin
    y = x;
    if (x == {1'b1, {(COEFF_W-1){1'b0}}}) begin
      y = ABS_MAX;
    end else if (x[COEFF_W-1]) begin
      y = COEFF_W'(-x);
    end
  end

endmodule

// File: rtl/dwt_feature_extractor.sv
// Windowed max/min/mean/abs-sum feature extractor for one DWT sub-band stream.
module dwt_feature_extractor
  import dwt_feat_pkg::*;
#(
  parameter  int LENGTH = 8,
  localparam int CW     = $clog2(LENGTH),
  localparam int AW     = f_aw(LENGTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [COEFF_W-1:0] coeff_in,
  output logic                      valid,
  output logic signed [COEFF_W-1:0] max,
  output logic signed [COEFF_W-1:0] min,
  output logic signed [AW-1:0]      mean,
  output logic        [AW-1:0]      sum
);

  logic        [CW-1:0]      cnt;
  logic signed [AW-1:0]      acc;
  logic        [AW-1:0]      abs_acc;
  logic signed [COEFF_W-1:0] run_max;
  logic signed [COEFF_W-1:0] run_min;

  logic        [COEFF_W-1:0] abs_in;
  logic signed [AW-1:0]      acc_next;
  logic        [AW-1:0]      abs_next;
  logic signed [AW-1:0]      mean_next;
  logic signed [COEFF_W-1:0] max_next;
  logic signed [COEFF_W-1:0] min_next;
  logic                      last;

  dwt_feat_abs u_abs (
    .x (coeff_in),
    .y (abs_in)
  );

  // Running values including the current sample; sample 0 seeds max/min directly.
  always_comb begin
    last      = (cnt == CW'(LENGTH - 1));
    acc_next  = acc + {{CW{coeff_in[COEFF_W-1]}}, coeff_in};
    abs_next  = abs_acc + {{CW{1'b0}}, abs_in};
    mean_next = acc_next >>> CW;
    max_next  = coeff_in;
    min_next  = coeff_in;
    if (cnt != '0) begin
      max_next = (coeff_in > run_max) ? coeff_in : run_max;
      min_next = (coeff_in < run_min) ? coeff_in : run_min;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      abs_acc <= '0;
      run_max <= '0;
      run_min <= '0;
      valid   <= 1'b0;
      max     <= '0;
      min     <= '0;
      mean    <= '0;
      sum     <= '0;
    end else begin
      valid <= 1'b0;
      if (en) begin
        run_max <= max_next;
        run_min <= min_next;
        if (last) begin
          cnt     <= '0;
          acc     <= '0;
          abs_acc <= '0;
          valid   <= 1'b1;
          max     <= max_next;
          min     <= min_next;
          mean    <= mean_next;
          sum     <= abs_next;
        end else begin
          cnt     <= cnt + CW'(1);
          acc     <= acc_next;
          abs_acc <= abs_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_dwt_feature_extractor.sv
// Directed self-checking bench for dwt_feature_extractor with LENGTH=8.
module tb_dwt_feature_extractor;

  localparam int AW = 35;

  logic          clk;
  logic          rst;
  logic          en;
  logic [31:0]   coeff_in;
  logic          valid_o;
  logic [31:0]   max_o;
  logic [31:0]   min_o;
  logic [AW-1:0] mean_o;
  logic [AW-1:0] sum_o;

  int vectors;
  int miscompares;

  dwt_feature_extractor #(.LENGTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .coeff_in (coeff_in),
    .valid    (valid_o),
    .max      (max_o),
    .min      (min_o),
    .mean     (mean_o),
    .sum      (sum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic e, input logic [31:0] c);
    en       = e;
    coeff_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkFeatures(input string tag, input logic v, input logic [31:0] mx,
                               input logic [31:0] mn, input logic [AW-1:0] me,
                               input logic [AW-1:0] su);
    checkOutput({tag, ".valid"}, 64'(valid_o), 64'(v));
    checkOutput({tag, ".max"},   64'(max_o),   64'(mx));
    checkOutput({tag, ".min"},   64'(min_o),   64'(mn));
    checkOutput({tag, ".mean"},  64'(mean_o),  64'(me));
    checkOutput({tag, ".sum"},   64'(sum_o),   64'(su));
  endtask

  initial begin
    logic [31:0] arb [6];
    vectors     = 0;
    miscompares = 0;
    arb[0] = 32'd5;   arb[1] = 32'hFFFF_FFFD; arb[2] = 32'd100;
    arb[3] = 32'hFFFF_FF38; arb[4] = 32'd7;   arb[5] = 32'd0;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0);
    rst = 1'b0;
    checkFeatures("reset", 1'b0, 32'd0, 32'd0, 35'd0, 35'd0);

    // Scenario 1: 1..8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i));
      if (i < 8) checkOutput("s1.valid_mid", 64'(valid_o), 64'd0);
    end
    checkFeatures("s1", 1'b1, 32'd8, 32'd1, 35'd4, 35'd36);

    // Scenario 2: -1..-8, mean is floor(-4.5) = -5
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(-i));
    checkFeatures("s2", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 35'h7_FFFF_FFFB, 35'd36);

    // Scenario 3: 6 arbitrary values then 18 x 0x7FFFFFFF
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1'b1, (k <= 6) ? arb[k-1] : 32'h7FFF_FFFF);
      checkOutput("s3.valid", 64'(valid_o), (k % 8 == 0) ? 64'd1 : 64'd0);
      if (k == 8)
        checkFeatures("s3.w1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FF38, 35'h1FFF_FFF4, 35'h1_0000_0139);
      if (k == 16)
        checkFeatures("s3.w2", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 35'h7FFF_FFFF, 35'h3_FFFF_FFF8);
    end

    // Scenario 4: most negative value, saturated abs
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h8000_0000);
    checkFeatures("s4", 1'b1, 32'h8000_0000, 32'h8000_0000, 35'h7_8000_0000, 35'h3_FFFF_FFF8);

    // Scenario 5: 1..8 with en gaps; outputs hold the previous window meanwhile
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i));
      if (i == 3 || i == 6) begin
        applyStimulus(1'b0, 32'hDEAD_BEEF);
        checkFeatures("s5.gap", 1'b0, 32'h8000_0000, 32'h8000_0000, 35'h7_8000_0000, 35'h3_FFFF_FFF8);
        applyStimulus(1'b0, 32'h0000_1234);
      end
    end
    checkFeatures("s5", 1'b1, 32'd8, 32'd1, 35'd4, 35'd36);

    // Scenario 6: reset mid-window, then a fresh window of 3s
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'd9);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'd9);
      checkFeatures("s6.rst", 1'b0, 32'd0, 32'd0, 35'd0, 35'd0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'd3);
      if (i < 8) checkFeatures("s6.pre", 1'b0, 32'd0, 32'd0, 35'd0, 35'd0);
    end
    checkFeatures("s6", 1'b1, 32'd3, 32'd3, 35'd3, 35'd24);
    applyStimulus(1'b0, 32'd0);
    checkFeatures("s6.hold", 1'b0, 32'd3, 32'd3, 35'd3, 35'd24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
